song_sequencer: RTL and testbench

- Autoplay front end of the piano: walks a score stored in an external synchronous ROM, one entry at a time.
- Drives the 5-bit note index (0 = rest, 1..21 = three octaves × 7 notes) that the note-to-key LED decoder and the tone generator consume.
- Times each note in beats and inserts a short silent gap after every note, so repeated notes are audible as separate notes.
- Supports start, pause, stop and end-of-song detection.

---
 rtl/song_sequencer_if.sv | 27 ++
 rtl/song_sequencer.sv | 157 +++++++++++++++
 tb/tb_song_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/song_sequencer_if.sv
// Bundle between the autoplay sequencer and its surroundings: host controls,
// the external score ROM and the downstream note decoder.
`timescale 1ns/1ps
interface song_sequencer_if #(
  parameter int ADDR_W = 8
) ();
  logic              start;
  logic              stop;
  logic              pause;
  logic [ADDR_W-1:0] song_base;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [4:0]        note;
  logic              playing;
  logic              beat;
  logic              done;

  modport master (
    input  start, stop, pause, song_base, rom_data,
    output rom_addr, note, playing, beat, done
  );

  modport slave (
    output start, stop, pause, song_base, rom_data,
    input  rom_addr, note, playing, beat, done
  );
endinterface

// File: rtl/song_sequencer.sv
// Autoplay score walker: fetches one score word at a time, holds the note for
// dur beats minus a short silent gap, and emits beat/done pulses.
`timescale 1ns/1ps
module song_sequencer #(
  parameter int BEAT_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int ADDR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  song_sequencer_if.master bus
);

  localparam int CNT_W  = $clog2(7 * BEAT_CYCLES + 1);
  localparam int BCNT_W = $clog2(BEAT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  BEAT_LEN  = CNT_W'(BEAT_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_LEN   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BEAT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [4:0]        NOTE_MAX  = 5'd21;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [4:0]        note_q, note_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              playing_q, playing_d;
  logic              beat_q, beat_d;
  logic              done_q, done_d;

  logic              hold;
  logic [4:0]        word_note;
  logic [2:0]        word_dur;

  assign word_note = bus.rom_data[7:3];
  assign word_dur  = bus.rom_data[2:0];

  // pause only freezes the timed part of an entry; fetch/load always complete
  assign hold = bus.pause && ((state_q == PLAY) || (state_q == GAP));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    note_d     = note_q;
    rom_addr_d = rom_addr_q;
    done_d     = 1'b0;

    if (bus.stop) begin
      state_d    = IDLE;
      cnt_d      = '0;
      bcnt_d     = '0;
      note_d     = '0;
      rom_addr_d = '0;
    end else if (!hold) begin
      case (state_q)
        IDLE: begin
          note_d = '0;
          if (bus.start) begin
            rom_addr_d = bus.song_base;
            state_d    = FETCH;
          end
        end

        FETCH: state_d = LOAD;

        LOAD: begin
          bcnt_d = '0;
          if (word_dur == 3'd0) begin
            note_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // out-of-range indices still consume their duration, silently
            note_d  = (word_note > NOTE_MAX) ? 5'd0 : word_note;
            cnt_d   = (CNT_W'(word_dur) * BEAT_LEN) - GAP_LEN;
            state_d = PLAY;
          end
        end

        PLAY: begin
          bcnt_d = (bcnt_q == BEAT_LAST) ? '0 : bcnt_q + BCNT_ONE;
          if (cnt_q == CNT_ONE) begin
            note_d  = '0;
            cnt_d   = GAP_LEN;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        GAP: begin
          bcnt_d = (bcnt_q == BEAT_LAST) ? '0 : bcnt_q + BCNT_ONE;
          note_d = '0;
          if (cnt_q == CNT_ONE) begin
            cnt_d      = '0;
            rom_addr_d = rom_addr_q + ADDR_ONE;
            state_d    = FETCH;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_d = IDLE;
          note_d  = '0;
        end
      endcase
    end
  end

  // beat is registered as "the coming cycle closes a beat"; a held cycle keeps it armed
  always_comb begin
    playing_d = (state_d != IDLE);
    beat_d    = ((state_d == PLAY) || (state_d == GAP)) && (bcnt_d == BEAT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      note_q     <= '0;
      rom_addr_q <= '0;
      playing_q  <= 1'b0;
      beat_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      note_q     <= note_d;
      rom_addr_q <= rom_addr_d;
      playing_q  <= playing_d;
      beat_q     <= beat_d;
      done_q     <= done_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.note     = hold ? 5'd0 : note_q;
  assign bus.playing  = playing_q;
  assign bus.beat     = beat_q && !hold;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a per-cycle output trace is derived from
// the score rules and compared against the DUT every cycle while a song runs.
`timescale 1ns/1ps
module tb_song_sequencer;

  localparam int BEAT = 4;
  localparam int GAP  = 1;

  typedef struct packed {
    logic [4:0] note;
    logic       playing;
    logic       beat;
    logic       done;
    logic [7:0] addr;
  } rec_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       check_en = 1'b0;
  logic [7:0] rom [256];
  rec_t       model_q [$];
  rec_t       exp_q [$];
  int         n_tests  = 0;
  int         n_fail   = 0;
  int         cyc_idx  = 0;
  string      tname    = "reset";

  song_sequencer_if #(.ADDR_W(8)) bus_if ();

  song_sequencer #(
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES (GAP),
    .ADDR_W     (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial forever #5 clk = ~clk;

  // synchronous score ROM: data valid one cycle after the address
  always @(posedge clk) bus_if.rom_data <= rom[bus_if.rom_addr];

  function automatic rec_t dut_rec();
    rec_t r;
    r = {bus_if.note, bus_if.playing, bus_if.beat, bus_if.done, bus_if.rom_addr};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_rec(input rec_t e);
    rec_t a;
    a = dut_rec();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL trace %s[%0d]: got note=%0d playing=%b beat=%b done=%b addr=%02h, required note=%0d playing=%b beat=%b done=%b addr=%02h",
               tname, cyc_idx, a.note, a.playing, a.beat, a.done, a.addr,
               e.note, e.playing, e.beat, e.done, e.addr);
    end
  endtask

  task automatic compare_loop();
    rec_t e;
    forever begin
      @(negedge clk);
      if (check_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_rec(e);
        cyc_idx++;
      end
    end
  endtask

  // Expected outputs from the cycle after start: 2 silent overhead cycles per
  // entry, then dur*BEAT cycles of which the last GAP are silent, a beat on
  // every BEAT-th cycle; an end marker gives one done cycle, then idle.
  function automatic void model_song(input int base);
    int   addr;
    int   dur;
    int   idx;
    int   len;
    rec_t r;
    addr = base;
    model_q.delete();
    for (int entry = 0; entry < 32; entry++) begin
      r         = '0;
      r.playing = 1'b1;
      r.addr    = 8'(addr);
      model_q.push_back(r);
      model_q.push_back(r);
      dur = int'(rom[addr][2:0]);
      idx = int'(rom[addr][7:3]);
      if (dur == 0) begin
        r.playing = 1'b0;
        r.done    = 1'b1;
        model_q.push_back(r);
        r.done = 1'b0;
        for (int k = 0; k < 3; k++) model_q.push_back(r);
        return;
      end
      len = dur * BEAT;
      for (int k = 0; k < len; k++) begin
        r.note = (k < len - GAP && idx <= 21) ? 5'(idx) : 5'd0;
        r.beat = ((k % BEAT) == BEAT - 1);
        model_q.push_back(r);
      end
      addr = (addr + 1) % 256;
    end
  endfunction

  // a pause stretches the timeline: frozen, muted copies of the paused cycle
  function automatic void add_pause(input int at, input int n);
    rec_t r;
    r      = model_q[at];
    r.note = 5'd0;
    r.beat = 1'b0;
    for (int i = 0; i < n; i++) model_q.insert(at, r);
  endfunction

  function automatic void idle_trace(input int n);
    model_q.delete();
    for (int i = 0; i < n; i++) model_q.push_back(rec_t'(0));
  endfunction

  function automatic int count_note(input int v, input int from);
    int c = 0;
    for (int i = from; i < model_q.size(); i++) if (int'(model_q[i].note) == v) c++;
    return c;
  endfunction

  function automatic int nth_beat(input int n);
    int seen = 0;
    for (int i = 0; i < model_q.size(); i++) begin
      if (model_q[i].beat) begin
        if (seen == n) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic int done_at();
    for (int i = 0; i < model_q.size(); i++) if (model_q[i].done) return i;
    return -1;
  endfunction

  task automatic launch(input logic [7:0] base, input logic with_stop);
    @(posedge clk); #1;
    bus_if.song_base = base;
    bus_if.start     = 1'b1;
    bus_if.stop      = with_stop;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    cyc_idx      = 0;
    exp_q        = model_q;
    check_en     = 1'b1;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    chk({"drain ", tname}, 32'(exp_q.size()), 0);
    check_en = 1'b0;
    exp_q.delete();
    $display("[TB] %s: %0d cycles compared", tname, cyc_idx);
  endtask

  initial begin
    bus_if.start     = 1'b0;
    bus_if.stop      = 1'b0;
    bus_if.pause     = 1'b0;
    bus_if.song_base = 8'h00;
    foreach (rom[i]) rom[i] = 8'h00;
    rom[8'h10] = 8'h0A;
    rom[8'h11] = 8'h00;
    rom[8'h20] = 8'h39;
    rom[8'h21] = 8'h39;
    rom[8'h22] = 8'h00;
    rom[8'hFF] = 8'hF9;
    rom[8'h00] = 8'h00;
    fork
      compare_loop();
    join_none

    #2;
    chk("reset note", 32'(bus_if.note), 0);
    chk("reset playing", 32'(bus_if.playing), 0);
    chk("reset beat", 32'(bus_if.beat), 0);
    chk("reset done", 32'(bus_if.done), 0);
    chk("reset rom_addr", 32'(bus_if.rom_addr), 0);
    #20 rst_n = 1'b1;

    // single note, dur 2
    tname = "single";
    model_song(8'h10);
    chk("single note1 cycles", 32'(count_note(1, 0)), 7);
    chk("single beat0 idx", 32'(nth_beat(0)), 5);
    chk("single beat1 idx", 32'(nth_beat(1)), 9);
    chk("single done idx", 32'(done_at()), 12);
    launch(8'h10, 1'b0);
    drain();

    // repeated note separated by gap + fetch/load
    tname = "repeat";
    model_song(8'h20);
    chk("repeat note7 cycles", 32'(count_note(7, 0)), 6);
    chk("repeat done idx", 32'(done_at()), 14);
    launch(8'h20, 1'b0);
    drain();

    // start and stop together from IDLE: stop wins
    tname = "start_stop";
    idle_trace(4);
    launch(8'h30, 1'b1);
    drain();

    // pause for 5 cycles from the third sounding cycle
    tname = "pause";
    model_song(8'h10);
    add_pause(4, 5);
    chk("pause note1 after release", 32'(count_note(1, 9)), 5);
    chk("pause beat0 idx", 32'(nth_beat(0)), 10);
    chk("pause beat1 idx", 32'(nth_beat(1)), 14);
    chk("pause done idx", 32'(done_at()), 17);
    launch(8'h10, 1'b0);
    repeat (4) @(posedge clk);
    #1 bus_if.pause = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus_if.pause = 1'b0;
    drain();

    // stop mid-PLAY
    tname = "stop";
    model_song(8'h10);
    while (model_q.size() > 5) void'(model_q.pop_back());
    for (int i = 0; i < 4; i++) model_q.push_back(rec_t'(0));
    launch(8'h10, 1'b0);
    repeat (4) @(posedge clk);
    #1 bus_if.stop = 1'b1;
    @(posedge clk);
    #1 bus_if.stop = 1'b0;
    drain();

    // out-of-range note plays silent; address wraps to 0x00
    tname = "wrap";
    model_song(8'hFF);
    chk("wrap sounding cycles", 32'(model_q.size() - count_note(0, 0)), 0);
    chk("wrap second fetch addr", 32'(model_q[6].addr), 0);
    chk("wrap done idx", 32'(done_at()), 8);
    launch(8'hFF, 1'b0);
    drain();

    // asynchronous reset during the final GAP cycle
    tname = "async_reset";
    model_song(8'h10);
    while (model_q.size() > 8) void'(model_q.pop_back());
    launch(8'h10, 1'b0);
    drain();
    @(posedge clk);
    #3;
    chk("pre-reset playing", 32'(bus_if.playing), 1);
    chk("pre-reset gap beat", 32'(bus_if.beat), 1);
    rst_n = 1'b0;
    #1;
    chk("async note", 32'(bus_if.note), 0);
    chk("async playing", 32'(bus_if.playing), 0);
    chk("async beat", 32'(bus_if.beat), 0);
    chk("async done", 32'(bus_if.done), 0);
    chk("async rom_addr", 32'(bus_if.rom_addr), 0);
    #3 rst_n = 1'b1;
    tname = "post_reset_idle";
    idle_trace(6);
    cyc_idx  = 0;
    exp_q    = model_q;
    check_en = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
